// File: rtl/actor_scanner_pkg.sv
// Shared definitions for the per-scanline actor scanner.
// Cell field positions, cell geometry and FSM encoding.
package actor_scanner_pkg;

  localparam int POS_Y_MSB  = 11;
  localparam int POS_Y_LSB  = 6;
  localparam int POS_X_MSB  = 5;
  localparam int CELL_SHIFT = 3;
  localparam int ROW_W      = POS_Y_MSB - POS_Y_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  function automatic logic [ROW_W-1:0] cell_row(
    input logic [8:0] v
  );
    return v[8:CELL_SHIFT];
  endfunction

endpackage

// File: rtl/actor_scanner_if.sv
// Bus bundle between the scanner, the actor demux and the renderer.
// master = scanner side, slave = environment side.
interface actor_scanner_if #(
  parameter int MAX_SLOTS = 2
);
  logic                   line_start;
  logic [8:0]             vline;
  logic [2:0]             select;
  logic [11:0]            position_in;
  logic [7:0]             sprite_in;
  logic [MAX_SLOTS-1:0]   slot_valid;
  logic [6*MAX_SLOTS-1:0] slot_x;
  logic [8*MAX_SLOTS-1:0] slot_sprite;
  logic [3*MAX_SLOTS-1:0] slot_line;
  logic                   busy;
  logic                   done;
  logic                   overflow;

  modport master (
    input  line_start, vline,
    input  position_in, sprite_in,
    output select,
    output slot_valid, slot_x,
    output slot_sprite, slot_line,
    output busy, done, overflow
  );

  modport slave (
    output line_start, vline,
    output position_in, sprite_in,
    input  select,
    input  slot_valid, slot_x,
    input  slot_sprite, slot_line,
    input  busy, done, overflow
  );
endinterface

// File: rtl/actor_slot_list.sv
// Working slot buffer filled during a scan plus the committed copy
// the renderer reads; commit is a single-edge snapshot.
module actor_slot_list
  import actor_scanner_pkg::*;
#(
  parameter int MAX_SLOTS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic [5:0]             i_x,
  input  logic [7:0]             i_sprite,
  input  logic [2:0]             i_line,
  input  logic                   i_commit,
  output logic [MAX_SLOTS-1:0]   o_valid,
  output logic [6*MAX_SLOTS-1:0] o_x,
  output logic [8*MAX_SLOTS-1:0] o_sprite,
  output logic [3*MAX_SLOTS-1:0] o_line,
  output logic                   o_overflow
);

  localparam int CW = $clog2(MAX_SLOTS + 1);

  logic [CW-1:0]          r_count;
  logic                   r_ovf;
  logic [MAX_SLOTS-1:0]   r_valid;
  logic [6*MAX_SLOTS-1:0] r_x;
  logic [8*MAX_SLOTS-1:0] r_sprite;
  logic [3*MAX_SLOTS-1:0] r_line;

  logic                   r_c_ovf;
  logic [MAX_SLOTS-1:0]   r_c_valid;
  logic [6*MAX_SLOTS-1:0] r_c_x;
  logic [8*MAX_SLOTS-1:0] r_c_sprite;
  logic [3*MAX_SLOTS-1:0] r_c_line;

  logic w_full;

  assign w_full = (r_count == CW'(MAX_SLOTS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= '0;
      r_x        <= '0;
      r_sprite   <= '0;
      r_line     <= '0;
      r_c_ovf    <= 1'b0;
      r_c_valid  <= '0;
      r_c_x      <= '0;
      r_c_sprite <= '0;
      r_c_line   <= '0;
    end else begin
      if (i_clear) begin
        r_count  <= '0;
        r_ovf    <= 1'b0;
        r_valid  <= '0;
        r_x      <= '0;
        r_sprite <= '0;
        r_line   <= '0;
      end else if (i_push) begin
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          for (int k = 0; k < MAX_SLOTS; k++) begin
            if (r_count == CW'(k)) begin
              r_valid[k]        <= 1'b1;
              r_x[6*k +: 6]     <= i_x;
              r_sprite[8*k +: 8] <= i_sprite;
              r_line[3*k +: 3]  <= i_line;
            end
          end
          r_count <= r_count + 1'b1;
        end
      end
      // Unused working slots are zero, so the copy zeroes them too.
      if (i_commit) begin
        r_c_ovf    <= r_ovf;
        r_c_valid  <= r_valid;
        r_c_x      <= r_x;
        r_c_sprite <= r_sprite;
        r_c_line   <= r_line;
      end
    end
  end

  assign o_valid    = r_c_valid;
  assign o_x        = r_c_x;
  assign o_sprite   = r_c_sprite;
  assign o_line     = r_c_line;
  assign o_overflow = r_c_ovf;

endmodule

// File: rtl/actor_scanner.sv
// Per-scanline actor evaluator: walks the demux select over all
// actors, keeps those on the requested cell row, commits a slot list.
module actor_scanner
  import actor_scanner_pkg::*;
#(
  parameter int NUM_ACTORS = 2,
  parameter int MAX_SLOTS  = 2
) (
  input logic            clk,
  input logic            rst_n,
  actor_scanner_if.master bus
);

  localparam logic [2:0] LAST = 3'(NUM_ACTORS - 1);

  state_e     r_state;
  logic [8:0] r_vline;
  logic [2:0] r_select;
  logic       r_busy;
  logic       r_done;

  logic w_last;
  logic w_hit;
  logic w_push;
  logic w_commit;

  logic [MAX_SLOTS-1:0]   w_valid;
  logic [6*MAX_SLOTS-1:0] w_x;
  logic [8*MAX_SLOTS-1:0] w_sprite;
  logic [3*MAX_SLOTS-1:0] w_line;
  logic                   w_ovf;

  assign w_last = (r_select == LAST);
  assign w_hit  = (bus.position_in[POS_Y_MSB:POS_Y_LSB]
                   == cell_row(r_vline));

  // A line_start anywhere wins: it restarts and suppresses commit.
  assign w_push   = (r_state == ST_SCAN) && !bus.line_start && w_hit;
  assign w_commit = (r_state == ST_COMMIT) && !bus.line_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_vline  <= '0;
      r_select <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.line_start) begin
        r_state  <= ST_SCAN;
        r_vline  <= bus.vline;
        r_select <= '0;
        r_busy   <= 1'b1;
      end else begin
        unique case (r_state)
          ST_SCAN: begin
            if (w_last) r_state <= ST_COMMIT;
            else        r_select <= r_select + 3'd1;
          end
          ST_COMMIT: begin
            r_state  <= ST_IDLE;
            r_select <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
          default: begin
            r_select <= '0;
          end
        endcase
      end
    end
  end

  actor_slot_list #(
    .MAX_SLOTS (MAX_SLOTS)
  ) u_list (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (bus.line_start),
    .i_push     (w_push),
    .i_x        (bus.position_in[POS_X_MSB:0]),
    .i_sprite   (bus.sprite_in),
    .i_line     (r_vline[CELL_SHIFT-1:0]),
    .i_commit   (w_commit),
    .o_valid    (w_valid),
    .o_x        (w_x),
    .o_sprite   (w_sprite),
    .o_line     (w_line),
    .o_overflow (w_ovf)
  );

  assign bus.select      = r_select;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.slot_valid  = w_valid;
  assign bus.slot_x      = w_x;
  assign bus.slot_sprite = w_sprite;
  assign bus.slot_line   = w_line;
  assign bus.overflow    = w_ovf;

endmodule

// File: tb/tb_actor_scanner.sv
// Bench for actor_scanner: directed cases plus random actor sets
// checked against a list-based reference model.
module tb_actor_scanner;

  typedef struct packed {
    logic [7:0]  v;
    logic [63:0] x;
    logic [63:0] s;
    logic [63:0] l;
    logic        o;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [11:0] pos_a [8];
  logic [7:0]  spr_a [8];
  logic [11:0] pos_b [8];
  logic [7:0]  spr_b [8];
  exp_t        ea;
  exp_t        eb;

  always #5 clk = ~clk;

  actor_scanner_if #(.MAX_SLOTS(2)) ifa ();
  actor_scanner_if #(.MAX_SLOTS(1)) ifb ();

  actor_scanner #(.NUM_ACTORS(2), .MAX_SLOTS(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  actor_scanner #(.NUM_ACTORS(8), .MAX_SLOTS(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  // Behavioural actor demux.
  assign ifa.position_in = pos_a[ifa.select];
  assign ifa.sprite_in   = spr_a[ifa.select];
  assign ifb.position_in = pos_b[ifb.select];
  assign ifb.sprite_in   = spr_b[ifb.select];

  function automatic exp_t model(
    input int n, input int m,
    input logic [11:0] pos [8], input logic [7:0] spr [8],
    input int vl
  );
    exp_t r;
    int   hits [$];
    r = '0;
    for (int i = 0; i < n; i++)
      if (int'(pos[i]) / 64 == vl / 8) hits.push_back(i);
    for (int k = 0; k < hits.size() && k < m; k++) begin
      r.v[k]         = 1'b1;
      r.x[6*k +: 6]  = 6'(int'(pos[hits[k]]) % 64);
      r.s[8*k +: 8]  = spr[hits[k]];
      r.l[3*k +: 3]  = 3'(vl % 8);
    end
    r.o = hits.size() > m;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag);
    chk({tag, ".valid"}, 64'(ifa.slot_valid), 64'(ea.v));
    chk({tag, ".x"}, 64'(ifa.slot_x), ea.x);
    chk({tag, ".spr"}, 64'(ifa.slot_sprite), ea.s);
    chk({tag, ".line"}, 64'(ifa.slot_line), ea.l);
    chk({tag, ".ovf"}, 64'(ifa.overflow), 64'(ea.o));
  endtask

  task automatic chk_b(input string tag);
    chk({tag, ".valid"}, 64'(ifb.slot_valid), 64'(eb.v));
    chk({tag, ".x"}, 64'(ifb.slot_x), eb.x);
    chk({tag, ".spr"}, 64'(ifb.slot_sprite), eb.s);
    chk({tag, ".line"}, 64'(ifb.slot_line), eb.l);
    chk({tag, ".ovf"}, 64'(ifb.overflow), 64'(eb.o));
  endtask

  task automatic scan_a(input string tag, input logic [8:0] vl);
    int e;
    @(negedge clk);
    ifa.vline      = vl;
    ifa.line_start = 1'b1;
    @(negedge clk);
    ifa.line_start = 1'b0;
    e = 1;
    while (ifa.done !== 1'b1 && e < 50) begin
      @(negedge clk);
      e++;
    end
    chk({tag, ".lat"}, 64'(e), 64'd4);
    ea = model(2, 2, pos_a, spr_a, int'(vl));
    chk_a(tag);
  endtask

  task automatic scan_b(input string tag, input logic [8:0] vl);
    int          e;
    logic [23:0] sq;
    logic [23:0] esq;
    sq  = '0;
    esq = '0;
    for (int i = 0; i < 8; i++) esq[3*i +: 3] = 3'(i);
    @(negedge clk);
    ifb.vline      = vl;
    ifb.line_start = 1'b1;
    @(negedge clk);
    ifb.line_start = 1'b0;
    e = 1;
    sq[2:0] = ifb.select;
    while (ifb.done !== 1'b1 && e < 50) begin
      @(negedge clk);
      e++;
      if (e <= 8) sq[3*(e-1) +: 3] = ifb.select;
    end
    chk({tag, ".lat"}, 64'(e), 64'd10);
    chk({tag, ".selseq"}, 64'(sq), 64'(esq));
    eb = model(8, 1, pos_b, spr_b, int'(vl));
    chk_b(tag);
    @(negedge clk);
    chk({tag, ".selidle"}, 64'(ifb.select), 64'd0);
  endtask

  initial begin
    int          e;
    int          dn;
    logic [8:0]  vl;
    ifa.line_start = 1'b0;
    ifa.vline      = '0;
    ifb.line_start = 1'b0;
    ifb.vline      = '0;
    for (int i = 0; i < 8; i++) begin
      pos_a[i] = '0;
      spr_a[i] = '0;
      pos_b[i] = '0;
      spr_b[i] = '0;
    end
    ea = '0;
    eb = '0;

    #2 rst_n = 1'b0;
    #1;
    chk_a("rst_a");
    chk_b("rst_b");
    chk("rst.busy", 64'({ifa.busy, ifb.busy}), 64'd0);
    chk("rst.done", 64'({ifa.done, ifb.done}), 64'd0);
    chk("rst.sel", 64'({ifa.select, ifb.select}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single hit
    pos_a[0] = {6'd5, 6'd10};
    spr_a[0] = 8'h21;
    pos_a[1] = {6'd9, 6'd4};
    spr_a[1] = 8'h33;
    scan_a("single", 9'd43);
    chk("single.v", 64'(ifa.slot_valid), 64'h1);
    chk("single.x0", 64'(ifa.slot_x[5:0]), 64'd10);
    chk("single.s0", 64'(ifa.slot_sprite[7:0]), 64'h21);
    chk("single.l0", 64'(ifa.slot_line[2:0]), 64'd3);
    @(negedge clk);
    chk("single.donepulse", 64'(ifa.done), 64'd0);
    chk("single.hold", 64'(ifa.slot_valid), 64'h1);

    // Both hit
    pos_a[0] = {6'd5, 6'd1};
    pos_a[1] = {6'd5, 6'd2};
    scan_a("both", 9'd40);
    chk("both.v", 64'(ifa.slot_valid), 64'h3);
    chk("both.x", 64'(ifa.slot_x), 64'(12'b000010_000001));

    // Overflow on the 8-actor, 1-slot instance
    for (int i = 0; i < 8; i++) begin
      pos_b[i] = {6'd20, 6'(i + 1)};
      spr_b[i] = 8'(8'h40 + i);
    end
    pos_b[0] = {6'd5, 6'd7};
    pos_b[1] = {6'd5, 6'd9};
    scan_b("ovf", 9'd40);
    chk("ovf.o", 64'(ifb.overflow), 64'd1);
    chk("ovf.x0", 64'(ifb.slot_x), 64'd7);
    scan_b("noh", 9'd300);
    chk("noh.v", 64'(ifb.slot_valid), 64'd0);

    // Restart mid-scan
    pos_a[0] = {6'd1, 6'd7};
    spr_a[0] = 8'h55;
    pos_a[1] = {6'd5, 6'd3};
    spr_a[1] = 8'h66;
    @(negedge clk);
    ifa.vline      = 9'd43;
    ifa.line_start = 1'b1;
    @(negedge clk);
    ifa.line_start = 1'b0;
    @(negedge clk);
    ifa.vline      = 9'd8;
    ifa.line_start = 1'b1;
    chk("rs.hold", 64'(ifa.slot_valid), 64'(ea.v));
    @(negedge clk);
    ifa.line_start = 1'b0;
    e = 3;
    while (ifa.done !== 1'b1 && e < 50) begin
      @(negedge clk);
      e++;
    end
    chk("rs.lat", 64'(e), 64'd6);
    ea = model(2, 2, pos_a, spr_a, 8);
    chk_a("rs");

    // Reset mid-scan
    pos_a[1] = {6'd1, 6'd3};
    @(negedge clk);
    ifa.vline      = 9'd12;
    ifa.line_start = 1'b1;
    @(negedge clk);
    ifa.line_start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    ea = '0;
    eb = '0;
    chk_a("mrst");
    chk("mrst.busy", 64'(ifa.busy), 64'd0);
    chk("mrst.sel", 64'(ifa.select), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifa.done === 1'b1) dn++;
    end
    chk("mrst.nodone", 64'(dn), 64'd0);
    chk_a("mrst_after");

    // Random actor sets
    for (int it = 0; it < 15; it++) begin
      vl = 9'($urandom_range(0, 511));
      for (int i = 0; i < 2; i++) begin
        pos_a[i] = {($urandom_range(0, 1) != 0) ? 6'(vl / 8)
                      : 6'($urandom_range(0, 63)),
                    6'($urandom_range(0, 63))};
        spr_a[i] = 8'($urandom_range(0, 255));
      end
      scan_a("rnd_a", vl);
    end
    for (int it = 0; it < 8; it++) begin
      vl = 9'($urandom_range(0, 511));
      for (int i = 0; i < 8; i++) begin
        pos_b[i] = {($urandom_range(0, 2) == 0) ? 6'(vl / 8)
                      : 6'($urandom_range(0, 63)),
                    6'($urandom_range(0, 63))};
        spr_b[i] = 8'($urandom_range(0, 255));
      end
      scan_b("rnd_b", vl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
